pipe_hazard_ctrl: RTL and testbench

//  Central hazard and stall sequencer for the 5-stage pipelined CPU with memory-mapped IO.

---
 rtl/pipe_hazard_ctrl_if.sv | 45 ++++
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM hazard inputs toward the controller,
// forwarding selects, pipeline enables and debug state back to the pipeline.
interface pipe_hazard_ctrl_if;
  localparam int unsigned REG_W = 5;

  logic [REG_W-1:0] drs;
  logic [REG_W-1:0] drt;
  logic             d_use_rs;
  logic             d_use_rt;
  logic [REG_W-1:0] ern;
  logic             ewreg;
  logic             em2reg;
  logic [REG_W-1:0] mrn;
  logic             mwreg;
  logic             mm2reg;
  logic [1:0]       pcsource;
  logic             io_req;
  logic             io_ready;

  logic [1:0]       fw_a;
  logic [1:0]       fw_b;
  logic             wpcir;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_en;
  logic             memwb_en;
  logic             io_err;
  logic [1:0]       fsm_state;

  // Pipeline side
  modport master (
    output drs, drt, d_use_rs, d_use_rt, ern, ewreg, em2reg, mrn, mwreg, mm2reg,
           pcsource, io_req, io_ready,
    input  fw_a, fw_b, wpcir, ifid_flush, idex_bubble, exmem_en, memwb_en, io_err,
           fsm_state
  );

  // Hazard controller side
  modport slave (
    input  drs, drt, d_use_rs, d_use_rt, ern, ewreg, em2reg, mrn, mwreg, mm2reg,
           pcsource, io_req, io_ready,
    output fw_a, fw_b, wpcir, ifid_flush, idex_bubble, exmem_en, memwb_en, io_err,
           fsm_state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage CPU: forwarding, load-use stall, branch flush
// and IO freeze with timeout. Optional event counters via `define HAZ_STATS_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned IO_TIMEOUT = 255,
  parameter int unsigned TO_W       = 16
) (
  input  logic                clock,
  input  logic                resetn,
  pipe_hazard_ctrl_if.slave   hz
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         flush_cnt,
  output logic [31:0]         iowait_cnt
`endif
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_IO_WAIT = 2'b01,
    ST_IO_DONE = 2'b10
  } state_e;

  state_e          state_q;
  logic [TO_W-1:0] cnt_q;

  logic       ldstall;
  logic       frozen;
  logic       timeout;
  logic [1:0] fw_a;
  logic [1:0] fw_b;
  logic       wpcir;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       pipe_en;

  // Forwarding: EX ALU result is youngest; EX loads fall through to the MEM check
  always_comb begin
    fw_a = 2'b00;
    if (hz.d_use_rs && (hz.drs != 5'd0)) begin
      if (hz.ewreg && (hz.ern == hz.drs) && !hz.em2reg) fw_a = 2'b01;
      else if (hz.mwreg && (hz.mrn == hz.drs))        fw_a = hz.mm2reg ? 2'b11 : 2'b10;
    end
    fw_b = 2'b00;
    if (hz.d_use_rt && (hz.drt != 5'd0)) begin
      if (hz.ewreg && (hz.ern == hz.drt) && !hz.em2reg) fw_b = 2'b01;
      else if (hz.mwreg && (hz.mrn == hz.drt))        fw_b = hz.mm2reg ? 2'b11 : 2'b10;
    end
  end

  assign ldstall = hz.ewreg && hz.em2reg && (hz.ern != 5'd0) &&
                   ((hz.d_use_rs && (hz.ern == hz.drs)) ||
                    (hz.d_use_rt && (hz.ern == hz.drt)));

  // IO_DONE deliberately ignores io_req: the access completes there
  assign frozen  = ((state_q == ST_RUN) && hz.io_req && !hz.io_ready) ||
                   (state_q == ST_IO_WAIT);
  assign timeout = (state_q == ST_IO_WAIT) && !hz.io_ready &&
                   (cnt_q == TO_W'(IO_TIMEOUT - 1));

  // Pipeline control; everything held off while reset is asserted
  always_comb begin
    wpcir       = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_en     = 1'b0;
    if (resetn && !frozen) begin
      pipe_en = 1'b1;
      if (ldstall) begin
        idex_bubble = 1'b1;
      end else begin
        wpcir      = 1'b1;
        ifid_flush = (hz.pcsource != 2'b00);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          cnt_q <= '0;
          if (hz.io_req && !hz.io_ready) state_q <= ST_IO_WAIT;
        end
        ST_IO_WAIT: begin
          if (cnt_q != TO_W'(IO_TIMEOUT)) cnt_q <= cnt_q + TO_W'(1);
          if (hz.io_ready || timeout) state_q <= ST_IO_DONE;
        end
        ST_IO_DONE: begin
          cnt_q   <= '0;
          state_q <= ST_RUN;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign hz.fw_a        = fw_a;
  assign hz.fw_b        = fw_b;
  assign hz.wpcir       = wpcir;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.exmem_en    = pipe_en;
  assign hz.memwb_en    = pipe_en;
  assign hz.io_err      = resetn && timeout;
  assign hz.fsm_state   = state_q;

`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] iowait_cnt_q;

  // Free-running event counters, wrap at 2^32
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      iowait_cnt_q <= '0;
    end else begin
      if (idex_bubble) stall_cnt_q  <= stall_cnt_q  + CNT_W'(1);
      if (ifid_flush)  flush_cnt_q  <= flush_cnt_q  + CNT_W'(1);
      if (frozen)      iowait_cnt_q <= iowait_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign iowait_cnt = iowait_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized plus directed bench for pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int unsigned TO = 8;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  pipe_hazard_ctrl_if hz();

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt, flush_cnt, iowait_cnt;
`endif

  pipe_hazard_ctrl #(.IO_TIMEOUT(TO), .TO_W(16)) dut (
    .clock  (clock),
    .resetn (resetn),
    .hz     (hz)
`ifdef HAZ_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
    .iowait_cnt (iowait_cnt)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model: 0 = running, 1 = waiting on IO, 2 = IO just completed
  int          mode   = 0;
  int unsigned waited = 0;

  // Last observed outputs, for directed sequence checks
  logic o_flush, o_bubble, o_wpcir, o_en, o_err;
  logic [1:0] o_fwa;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd(input logic use_r, input logic [4:0] r);
    if (!use_r || r == 5'd0) return 2'b00;
    if (hz.ewreg && hz.ern == r && !hz.em2reg) return 2'b01;
    if (hz.mwreg && hz.mrn == r) return hz.mm2reg ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  // Called at a negedge with inputs set; checks outputs, advances one clock
  task automatic step();
    logic ld, hold;
    int   e_wp, e_fl, e_bb, e_en, e_err, nmode;
    int unsigned nwait;
    #1;
    ld = hz.ewreg && hz.em2reg && hz.ern != 5'd0 &&
         ((hz.d_use_rs && hz.ern == hz.drs) || (hz.d_use_rt && hz.ern == hz.drt));
    hold = (mode == 0 && hz.io_req && !hz.io_ready) || mode == 1;
    e_wp = 0; e_fl = 0; e_bb = 0; e_en = 0;
    if (resetn && !hold) begin
      e_en = 1;
      if (ld) e_bb = 1;
      else begin
        e_wp = 1;
        e_fl = (hz.pcsource != 2'b00) ? 1 : 0;
      end
    end
    e_err = (resetn && mode == 1 && !hz.io_ready && waited == TO - 1) ? 1 : 0;

    check("fw_a",        32'(hz.fw_a),        32'(fwd(hz.d_use_rs, hz.drs)));
    check("fw_b",        32'(hz.fw_b),        32'(fwd(hz.d_use_rt, hz.drt)));
    check("wpcir",       32'(hz.wpcir),       e_wp);
    check("ifid_flush",  32'(hz.ifid_flush),  e_fl);
    check("idex_bubble", 32'(hz.idex_bubble), e_bb);
    check("exmem_en",    32'(hz.exmem_en),    e_en);
    check("memwb_en",    32'(hz.memwb_en),    e_en);
    check("io_err",      32'(hz.io_err),      e_err);
    check("fsm_state",   32'(hz.fsm_state),   mode);

    o_flush = hz.ifid_flush; o_bubble = hz.idex_bubble; o_wpcir = hz.wpcir;
    o_en = hz.exmem_en; o_err = hz.io_err; o_fwa = hz.fw_a;

    nmode = mode; nwait = waited;
    if (!resetn) begin
      nmode = 0; nwait = 0;
    end else if (mode == 0) begin
      nwait = 0;
      if (hz.io_req && !hz.io_ready) nmode = 1;
    end else if (mode == 1) begin
      if (hz.io_ready || waited == TO - 1) nmode = 2;
      nwait = waited + 1;
    end else begin
      nmode = 0; nwait = 0;
    end
    @(posedge clock);
    mode = nmode; waited = nwait;
    @(negedge clock);
  endtask

  task automatic quiet();
    hz.drs = 5'd0; hz.drt = 5'd0; hz.d_use_rs = 1'b0; hz.d_use_rt = 1'b0;
    hz.ern = 5'd0; hz.ewreg = 1'b0; hz.em2reg = 1'b0;
    hz.mrn = 5'd0; hz.mwreg = 1'b0; hz.mm2reg = 1'b0;
    hz.pcsource = 2'b00; hz.io_req = 1'b0; hz.io_ready = 1'b0;
  endtask

  initial begin
    int err_at, frz;
    resetn = 1'b0;
    quiet();
    #2;
    check("rst_state", 32'(hz.fsm_state), 0);
    check("rst_wpcir", 32'(hz.wpcir), 0);
    check("rst_en",    32'(hz.exmem_en), 0);
    check("rst_ioerr", 32'(hz.io_err), 0);
    @(negedge clock);
    resetn = 1'b1;
    step();

    // Load-use: one bubble, then MEM load forwards via 11
    hz.drs = 5'd2; hz.d_use_rs = 1'b1; hz.ern = 5'd2; hz.ewreg = 1'b1; hz.em2reg = 1'b1;
    step();
    check("t1_bubble", 32'(o_bubble), 1);
    check("t1_hold",   32'(o_wpcir), 0);
    hz.ewreg = 1'b0; hz.em2reg = 1'b0; hz.ern = 5'd0;
    hz.mrn = 5'd2; hz.mwreg = 1'b1; hz.mm2reg = 1'b1;
    step();
    check("t1_fw", 32'(o_fwa), 32'h3);
    check("t1_go", 32'(o_wpcir), 1);

    // EX beats MEM; $0 never forwards
    quiet();
    hz.drs = 5'd3; hz.d_use_rs = 1'b1; hz.ern = 5'd3; hz.ewreg = 1'b1;
    hz.mrn = 5'd3; hz.mwreg = 1'b1;
    step();
    check("t2_ex_wins", 32'(o_fwa), 32'h1);
    hz.drs = 5'd0; hz.ern = 5'd0; hz.mrn = 5'd0;
    step();
    check("t2_r0", 32'(o_fwa), 32'h0);

    // Branch flush, and ldstall taking priority over it
    quiet();
    hz.pcsource = 2'b01;
    step();
    check("t3_flush", 32'(o_flush), 1);
    hz.drt = 5'd4; hz.d_use_rt = 1'b1; hz.ern = 5'd4; hz.ewreg = 1'b1; hz.em2reg = 1'b1;
    step();
    check("t3_ld_noflush", 32'(o_flush), 0);
    check("t3_ld_bubble",  32'(o_bubble), 1);
    hz.ewreg = 1'b0; hz.em2reg = 1'b0;
    step();
    check("t3_late_flush", 32'(o_flush), 1);

    // IO ready after 5 low cycles: 6 frozen cycles, no error
    quiet();
    hz.io_req = 1'b1;
    frz = 0;
    for (int k = 1; k <= 6; k++) begin
      hz.io_ready = (k == 6);
      step();
      if (!o_en) frz++;
      if (o_err) frz += 100;
    end
    hz.io_req = 1'b0; hz.io_ready = 1'b0;
    step();
    step();
    check("t4_frozen", frz, 6);

    // Timeout: error pulse on the 9th frozen cycle
    hz.io_req = 1'b1; hz.io_ready = 1'b0;
    err_at = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (o_err) err_at = (err_at == 0) ? k : 99;
    end
    check("t5_err_cycle", err_at, 9);

    // Reset while waiting on IO
    quiet();
    step(); step(); step();
    hz.io_req = 1'b1;
    step(); step(); step();
    resetn = 1'b0;
    mode = 0; waited = 0;
    #1;
    check("t6_async_state", 32'(hz.fsm_state), 0);
    check("t6_async_en",    32'(hz.exmem_en), 0);
    step();
    resetn = 1'b1;
    quiet();
    step();

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        resetn = 1'b0;
        mode = 0; waited = 0;
        step();
        resetn = 1'b1;
      end
      hz.drs      = 5'($urandom_range(0, 3));
      hz.drt      = 5'($urandom_range(0, 3));
      hz.d_use_rs = 1'($urandom_range(0, 1));
      hz.d_use_rt = 1'($urandom_range(0, 1));
      hz.ern      = 5'($urandom_range(0, 3));
      hz.ewreg    = 1'($urandom_range(0, 1));
      hz.em2reg   = 1'($urandom_range(0, 1));
      hz.mrn      = 5'($urandom_range(0, 3));
      hz.mwreg    = 1'($urandom_range(0, 1));
      hz.mm2reg   = 1'($urandom_range(0, 1));
      hz.pcsource = 2'($urandom_range(0, 3));
      hz.io_req   = ($urandom_range(0, 5) == 0);
      hz.io_ready = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
